// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states
// and small helpers used by both the datapath and the control logic.
package alu_pkg;

  // Width of the operation code field carried on the request bus.
  localparam int FUNC_W = 5;

  // Operation codes; every value not listed here is an illegal request.
  typedef enum logic [FUNC_W-1:0] {
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_SLT  = 5'd5,
    ALU_SLTU = 5'd6,
    ALU_XOR  = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_MUL  = 5'd11
  } alufunc_t;

  // Control states: IDLE accepts requests, MUL runs the iterative multiplier.
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // True for the only operation that takes the multi-cycle path.
  function automatic logic is_mul(input logic [FUNC_W-1:0] func);
    return func == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bus of the multi-cycle ALU. The requester drives the
// operands and takes results; the ALU drives ready/valid and the result.
interface alu_mc_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  srca;
  logic [WIDTH-1:0]  srcb;
  logic [FUNC_W-1:0] alufunc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              err;

  modport master (
    output in_valid, srca, srcb, alufunc, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, srca, srcb, alufunc, out_ready,
    output in_ready, out_valid, result, err
  );

endinterface

// File: rtl/alu_comb.sv
// Combinational part of the ALU: every single-cycle operation plus the
// illegal-opcode flag. Multiplication is handled by the iterative datapath
// in the top level, so it yields a zero result and no error here.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  srca,
  input  logic [WIDTH-1:0]  srcb,
  input  logic [FUNC_W-1:0] alufunc,
  output logic [WIDTH-1:0]  result,
  output logic              err
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = srcb[SHW-1:0];

  // Select the operation result; anything outside the opcode table is flagged.
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (alufunc_t'(alufunc))
      ALU_ADD:  result = srca + srcb;
      ALU_SUB:  result = srca - srcb;
      ALU_AND:  result = srca & srcb;
      ALU_OR:   result = srca | srcb;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      ALU_XOR:  result = srca ^ srcb;
      ALU_SLL:  result = srca << shamt;
      ALU_SRL:  result = srca >> shamt;
      ALU_SRA:  result = $signed(srca) >>> shamt;
      ALU_MUL:  result = '0;
      default:  err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top level. Single-cycle operations complete on the
// accepting edge; multiplication runs a shift-add loop, one multiplier bit
// per cycle, and presents its product WIDTH edges after acceptance.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  alu_mc_if.slave bus
);

  localparam int CNTW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             in_ready;
  logic             accept;
  logic             accept_mul;
  logic             accept_single;
  logic             mul_last;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] comb_result;
  logic             comb_err;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .srca   (bus.srca),
    .srcb   (bus.srcb),
    .alufunc(bus.alufunc),
    .result (comb_result),
    .err    (comb_err)
  );

  // Handshake decode and next-state selection for the IDLE/MUL controller.
  always_comb begin
    state_next    = state;
    in_ready      = (state == IDLE) && (!out_valid_q || bus.out_ready) && !reset;
    accept        = bus.in_valid && in_ready;
    accept_mul    = accept && is_mul(bus.alufunc);
    accept_single = accept && !is_mul(bus.alufunc);
    mul_last      = (state == MUL) && (cnt == CNTW'(WIDTH - 1));
    partial       = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: if (accept_mul) state_next = MUL;
      MUL:  if (mul_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Shift-add multiplier: operands latched on accept, one bit retired per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (accept_mul) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= bus.srca;
      mplier <= bus.srcb;
    end else if (state == MUL) begin
      cnt    <= cnt + 1'b1;
      acc    <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Output register: load a new result or hold it until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else if (accept_single) begin
      out_valid_q <= 1'b1;
      result_q    <= comb_result;
      err_q       <= comb_err;
    end else if (mul_last) begin
      out_valid_q <= 1'b1;
      result_q    <= partial;
      err_q       <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, >= 8.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port in_valid  input  1  request present on srca/srcb/alufunc.
REQ-005 Port in_ready  output  1  block accepts request this cycle.
REQ-006 Port srca  input  WIDTH  operand A.
REQ-007 Port srcb  input  WIDTH  operand B; low $clog2(WIDTH) bits are the shift amount for shifts.
REQ-008 Port alufunc  input  5  operation code.
REQ-009 Port out_valid  output  1  result/err valid.
REQ-010 Port out_ready  input  1  consumer takes result this cycle.
REQ-011 Port result  output  WIDTH  registered result.
REQ-012 Port err  output  1  registered illegal-opcode flag paired with result.

Function
REQ-013 Opcodes SHALL be: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT (signed, 1/0), 6 SLTU (unsigned), 7 XOR, 8 SLL, 9 SRL, 10 SRA, 11 MUL (low WIDTH bits of product); all other codes illegal.
REQ-014 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-015 Illegal code SHALL complete as a single-cycle op with result 0, err 1; legal ops give err 0.
REQ-016 Acceptance SHALL occur on an edge where in_valid && in_ready; operands and alufunc are captured then and may change afterwards.
REQ-017 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !reset.
REQ-018 States SHALL be IDLE and MUL; IDLE->MUL on accepting opcode 11; MUL->IDLE after WIDTH iterations; all other accepts stay in IDLE.
REQ-019 Single-cycle ops: result/out_valid SHALL be updated on the accepting edge (latency 1).
REQ-020 MUL: iterative shift-add, one multiplier bit per cycle; out_valid SHALL rise on the WIDTH-th edge after acceptance (latency WIDTH); in_ready 0 throughout MUL.
REQ-021 result/err SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid SHALL clear on an edge with out_ready unless a new single-cycle result is loaded on that same edge (back-to-back throughput of one op per cycle).
REQ-023 in_valid while in_ready is 0 SHALL be ignored without side effects.

Reset
REQ-024 While reset is high at an edge: state IDLE, out_valid 0, result 0, err 0, MUL counter/accumulator 0.
REQ-025 Reset during MUL SHALL abandon the operation; no result for it ever appears.
REQ-026 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-027 Package alu_pkg SHALL hold the 5-bit alufunc enum typedef, opcode constants and the IDLE/MUL state enum.
REQ-028 A combinational sub-module alu_comb (WIDTH-parametrised, all non-MUL ops plus err) SHALL compute single-cycle results; the MUL datapath and FSM live in alu_mc.

Verification (WIDTH=32)
REQ-029 ADD 10,5, out_ready=1 -> out_valid next cycle, result 15, err 0; SUB 10,15 -> 0xFFFFFFFB.
REQ-030 SLT 0xFFFFFFFB,3 -> 1; SLTU 0xFFFFFFFB,3 -> 0; SRA 0x80000000,4 -> 0xF8000000; SRL same -> 0x08000000.
REQ-031 MUL 7,6 -> out_valid exactly 32 cycles after accept, result 42, in_ready 0 meanwhile; MUL 0xFFFFFFFF,2 -> 0xFFFFFFFE.
REQ-032 Backpressure: out_ready=0 after AND 0xFF00FF00,0x0F0F0F0F -> result 0x0F000F00 held 5 cycles, in_ready 0, second op not taken; raise out_ready with OR pending -> OR accepted that edge, result 0xFF0FFF0F next cycle.
REQ-033 Reset asserted 10 cycles into MUL -> out_valid 0 after that edge, in_ready 1 after deassert, no result for that MUL.
REQ-034 alufunc 0 and 31 -> result 0, err 1, latency 1.
